// File: rtl/bus_sequencer.sv
// bus_sequencer: control-step sequencer for the single-bus CPU datapath.
// Walks the fetch/decode/execute microsteps T0..T6 and decodes the current
// step (plus the IR fields) into the bus source select and the register
// load strobes. Memory read waits are bounded by MAX_WAIT, and illegal
// opcodes are flagged. Both error flags are sticky until reset.
module bus_sequencer #(
    parameter int MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        run,
    input  logic        mem_rdy,
    input  logic [31:0] ir,
    output logic [4:0]  bus_sel,
    output logic        pc_in,
    output logic        inc_pc,
    output logic        mar_in,
    output logic        mdr_in,
    output logic        mem_read,
    output logic        ir_in,
    output logic        y_in,
    output logic        z_in,
    output logic        hi_in,
    output logic        lo_in,
    output logic [15:0] rf_in,
    output logic [4:0]  alu_op,
    output logic        instr_done,
    output logic        illegal,
    output logic        mem_err,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T0   = 3'd1,
        S_T1   = 3'd2,
        S_T2   = 3'd3,
        S_T3   = 3'd4,
        S_T4   = 3'd5,
        S_T5   = 3'd6,
        S_T6   = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        CLS_ALU  = 3'd0,
        CLS_IMM  = 3'd1,
        CLS_MUL  = 3'd2,
        CLS_DIV  = 3'd3,
        CLS_MFHI = 3'd4,
        CLS_MFLO = 3'd5,
        CLS_ILL  = 3'd6
    } cls_t;

    localparam logic [4:0] BUS_HI  = 5'd16;
    localparam logic [4:0] BUS_LO  = 5'd17;
    localparam logic [4:0] BUS_ZHI = 5'd18;
    localparam logic [4:0] BUS_ZLO = 5'd19;
    localparam logic [4:0] BUS_PC  = 5'd20;
    localparam logic [4:0] BUS_MDR = 5'd21;
    localparam logic [4:0] BUS_C   = 5'd23;

    // Last non-ready T1 cycle index before the fetch is abandoned.
    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    // Map an opcode onto its execution class.
    function automatic cls_t classify(input logic [4:0] op);
        cls_t c;
        if (op <= 5'd11) begin
            c = CLS_ALU;
        end else if (op <= 5'd14) begin
            c = CLS_IMM;
        end else begin
            case (op)
                5'd15:   c = CLS_MUL;
                5'd16:   c = CLS_DIV;
                5'd17:   c = CLS_MFHI;
                5'd18:   c = CLS_MFLO;
                default: c = CLS_ILL;
            endcase
        end
        return c;
    endfunction

    // One-hot register write enable; r0 is hard-wired zero and never written.
    function automatic logic [15:0] rf_onehot(input logic [3:0] ra);
        logic [15:0] v;
        if (ra != 4'd0) begin
            v = 16'd1 << ra;
        end else begin
            v = 16'd0;
        end
        return v;
    endfunction

    state_t      state_r;
    state_t      next_state_s;
    logic [7:0]  wait_cnt_r;
    logic [7:0]  wait_cnt_s;
    logic        illegal_r;
    logic        mem_err_r;
    logic        set_illegal_s;
    logic        set_mem_err_s;
    cls_t        cls_s;
    logic [4:0]  op_s;
    logic [3:0]  ra_s;
    logic [3:0]  rb_s;
    logic [3:0]  rc_s;
    logic        ir_unused_s;

    assign op_s        = ir[31:27];
    assign ra_s        = ir[26:23];
    assign rb_s        = ir[22:19];
    assign rc_s        = ir[18:15];
    assign ir_unused_s = ^ir[14:0];
    assign cls_s       = classify(op_s);

    assign illegal = illegal_r;
    assign mem_err = mem_err_r;
    assign busy    = (state_r != S_IDLE);

    // Control-step register; reset aborts any instruction in flight.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Memory-wait counter; only ever nonzero while stalled in T1.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            wait_cnt_r <= 8'd0;
        end else begin
            wait_cnt_r <= wait_cnt_s;
        end
    end

    // Sticky error flags; cleared only by reset, never block fetching.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            illegal_r <= 1'b0;
            mem_err_r <= 1'b0;
        end else begin
            illegal_r <= illegal_r | set_illegal_s;
            mem_err_r <= mem_err_r | set_mem_err_s;
        end
    end

    // Next-step selection and Moore decode of the current step into strobes.
    always_comb begin
        next_state_s  = state_r;
        wait_cnt_s    = 8'd0;
        set_illegal_s = 1'b0;
        set_mem_err_s = 1'b0;
        bus_sel       = 5'd0;
        pc_in         = 1'b0;
        inc_pc        = 1'b0;
        mar_in        = 1'b0;
        mdr_in        = 1'b0;
        mem_read      = 1'b0;
        ir_in         = 1'b0;
        y_in          = 1'b0;
        z_in          = 1'b0;
        hi_in         = 1'b0;
        lo_in         = 1'b0;
        rf_in         = 16'd0;
        alu_op        = 5'd0;
        instr_done    = 1'b0;

        case (state_r)
            S_IDLE: begin
                if (run) begin
                    next_state_s = S_T0;
                end else begin
                    next_state_s = S_IDLE;
                end
            end

            S_T0: begin
                bus_sel      = BUS_PC;
                mar_in       = 1'b1;
                inc_pc       = 1'b1;
                z_in         = 1'b1;
                next_state_s = S_T1;
            end

            S_T1: begin
                // PC reload from Z happens once; later wait cycles only hold the read.
                bus_sel  = BUS_ZLO;
                pc_in    = (wait_cnt_r == 8'd0);
                mem_read = 1'b1;
                mdr_in   = 1'b1;
                if (mem_rdy) begin
                    next_state_s = S_T2;
                end else if (wait_cnt_r >= WAIT_LAST) begin
                    next_state_s  = S_IDLE;
                    set_mem_err_s = 1'b1;
                end else begin
                    next_state_s = S_T1;
                    wait_cnt_s   = wait_cnt_r + 8'd1;
                end
            end

            S_T2: begin
                bus_sel      = BUS_MDR;
                ir_in        = 1'b1;
                next_state_s = S_T3;
            end

            S_T3: begin
                case (cls_s)
                    CLS_ALU, CLS_IMM, CLS_MUL, CLS_DIV: begin
                        bus_sel      = {1'b0, rb_s};
                        y_in         = 1'b1;
                        next_state_s = S_T4;
                    end
                    CLS_MFHI: begin
                        bus_sel      = BUS_HI;
                        rf_in        = rf_onehot(ra_s);
                        instr_done   = 1'b1;
                        next_state_s = run ? S_T0 : S_IDLE;
                    end
                    CLS_MFLO: begin
                        bus_sel      = BUS_LO;
                        rf_in        = rf_onehot(ra_s);
                        instr_done   = 1'b1;
                        next_state_s = run ? S_T0 : S_IDLE;
                    end
                    default: begin
                        set_illegal_s = 1'b1;
                        instr_done    = 1'b1;
                        next_state_s  = run ? S_T0 : S_IDLE;
                    end
                endcase
            end

            S_T4: begin
                if (cls_s == CLS_IMM) begin
                    bus_sel = BUS_C;
                end else begin
                    bus_sel = {1'b0, rc_s};
                end
                alu_op       = op_s;
                z_in         = 1'b1;
                next_state_s = S_T5;
            end

            S_T5: begin
                bus_sel = BUS_ZLO;
                if ((cls_s == CLS_MUL) || (cls_s == CLS_DIV)) begin
                    lo_in        = 1'b1;
                    next_state_s = S_T6;
                end else begin
                    rf_in        = rf_onehot(ra_s);
                    instr_done   = 1'b1;
                    next_state_s = run ? S_T0 : S_IDLE;
                end
            end

            S_T6: begin
                bus_sel      = BUS_ZHI;
                hi_in        = 1'b1;
                instr_done   = 1'b1;
                next_state_s = run ? S_T0 : S_IDLE;
            end

            default: begin
                next_state_s = S_IDLE;
            end
        endcase
    end

endmodule

// File: doc/bus_sequencer.md
Name: bus_sequencer

Overview:
- Control-step sequencer for the single-bus CPU datapath.
- Drives the 5-bit bus source select consumed by the bus multiplexer and the register-load enables (PC, MAR, MDR, IR, Y, Z, HI, LO, r0-r15).
- Runs the fetch/decode/execute microsteps T0..T6 for ALU, immediate, mul/div and move-from-HI/LO instructions.
- Handles the memory-read wait and flags illegal opcodes.

Parameters:
- MAX_WAIT, 15, cycles T1 waits for mem_rdy before aborting with mem_err (range 1..255).

Ports:
- clk  input  1  rising-edge clock
- clr  input  1  asynchronous active-low reset
- run  input  1  level; 1 = keep fetching instructions
- mem_rdy  input  1  memory read data valid in MDR path
- ir  input  32  IR register contents: op=[31:27], ra=[26:23], rb=[22:19], rc=[18:15]
- bus_sel  output  5  bus source: 0-15 r0-r15, 16 HI, 17 LO, 18 ZHI, 19 ZLO, 20 PC, 21 MDR, 22 InPort, 23 C_sign_extended
- pc_in, inc_pc, mar_in, mdr_in, mem_read, ir_in, y_in, z_in, hi_in, lo_in  output  1 each  load/control strobes
- rf_in  output  16  one-hot register-file write enable
- alu_op  output  5  ALU operation; equals op in T4, else 0
- instr_done  output  1  one-cycle pulse on final step of each instruction
- illegal  output  1  sticky illegal-opcode flag
- mem_err  output  1  sticky memory-timeout flag
- busy  output  1  state != IDLE

Behaviour:
- Reset (clr=0, async): state=IDLE, wait counter=0, illegal=0, mem_err=0, all strobes/rf_in/alu_op/bus_sel=0, instr_done=0. Reset mid-instruction aborts immediately; no strobe survives.
- All outputs are Moore functions of registered state; no combinational path from inputs to outputs except as noted for T1.
- IDLE: run=1 -> T0 next cycle.
- T0: bus_sel=20, mar_in, inc_pc, z_in -> T1.
- T1: bus_sel=19, pc_in asserted only in the first T1 cycle. mem_read and mdr_in are held every T1 cycle.
  - mem_rdy=1 -> T2.
  - Otherwise wait counter increments. After MAX_WAIT non-ready cycles -> IDLE with mem_err=1.
  - The counter clears on leaving T1.
- T2: bus_sel=21, ir_in -> T3.
- Decode in T3 uses ir, already loaded at the end of T2:
  - R-type: op 00000-01011.
  - Immediate: 01100-01110.
  - mul: 01111.
  - div: 10000.
  - mfhi: 10001.
  - mflo: 10010.
  - Others are illegal.
- T3:
  - ALU, imm, mul, div: bus_sel=rb, y_in -> T4.
  - mfhi/mflo: bus_sel=16/17, rf_in[ra] -> END.
  - Illegal: illegal=1, all strobes 0 -> END.
- T4: bus_sel=rc for R-type/mul/div, 23 for imm; alu_op=op; z_in -> T5.
- T5:
  - bus_sel=19.
  - R/imm: rf_in[ra] -> END.
  - mul/div: lo_in -> T6.
- T6: bus_sel=18, hi_in -> END.
- END is not a separate state: instr_done is asserted in the instruction's last step. Next state is T0 if run=1 at that edge, else IDLE.
- rf_in:
  - ra=0 never asserts rf_in[0]; r0 is read-only zero. The step still takes its cycle and instr_done still pulses.
  - At most one rf_in bit is ever high.
- run deasserted mid-instruction: the instruction completes; halt occurs only at its final step.
- illegal and mem_err clear only on reset. They do not block further fetches.
- Fixed latency, mem_rdy high in first T1: R/imm 6 cycles; mul/div 7; mfhi/mflo 4; illegal 4.

Test Plan:
- Reset/idle: clr=0 while in T4, then release with run=0 -> all outputs 0 immediately and after release; busy stays 0.
- Fetch + add: run=1, mem_rdy=1, ir=op 00011 ra=3 rb=1 rc=2 -> bus_sel sequence 20,19,21,1,2,19. z_in in T0/T4, y_in in T3, rf_in=0x0008 in T5, alu_op=3 only in T4, instr_done on cycle 6.
- Immediate + r0 guard: ir=op 01100 ra=0 rb=5 -> T4 bus_sel=23. T5 rf_in=0x0000, instr_done still pulses cycle 6.
- mul: ir=op 01111 rb=4 rc=6 -> lo_in in T5 (bus_sel=19), hi_in in T6 (bus_sel=18), instr_done cycle 7; mflo ra=9 next -> rf_in=0x0200 at T3, bus_sel=17.
- Memory wait/timeout: mem_rdy low 3 cycles then high -> T1 lasts 4 cycles, pc_in only in the first; MAX_WAIT=15 and mem_rdy held 0 -> mem_err=1 after 15 T1 cycles, back to IDLE.
- Illegal/run drop: ir op=11111 -> illegal=1, no rf_in/hi_in/lo_in, 4-cycle instruction. run dropped during T4 of an add -> add completes, then IDLE, busy=0.
